// File: rtl/ext_write_buffer_if.sv
// Bus bundle for ext_write_buffer: CPU request side plus memory_controller side.
// Handshake: a CPU request is valid while cpu_cs_b=0, must be held stable, and is
// taken on the rising edge where cpu_clken=1. An mc access is presented while
// mc_cs_b=0, held stable, and completes on the rising edge where mc_clken=1.
interface ext_write_buffer_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 20
);
    logic             cpu_cs_b;
    logic             cpu_rnw;
    logic [ASIZE-1:0] cpu_addr;
    logic [DSIZE-1:0] cpu_dout;
    logic             cpu_clken;
    logic [DSIZE-1:0] cpu_din;
    logic             mc_cs_b;
    logic             mc_rnw;
    logic [ASIZE-1:0] mc_addr;
    logic [DSIZE-1:0] mc_dout;
    logic             mc_clken;
    logic [DSIZE-1:0] mc_din;

    // The buffer itself.
    modport slave (
        input  cpu_cs_b, cpu_rnw, cpu_addr, cpu_dout, mc_clken, mc_din,
        output cpu_clken, cpu_din, mc_cs_b, mc_rnw, mc_addr, mc_dout
    );

    // The surrounding CPU and memory_controller.
    modport master (
        output cpu_cs_b, cpu_rnw, cpu_addr, cpu_dout, mc_clken, mc_din,
        input  cpu_clken, cpu_din, mc_cs_b, mc_rnw, mc_addr, mc_dout
    );
endinterface

// File: rtl/ext_write_buffer.sv
// Posted-write buffer: CPU writes land in a small FIFO and drain to the memory
// controller in the background; reads wait for the drain, then run one access.
module ext_write_buffer #(
    parameter int DSIZE     = 32,
    parameter int ASIZE     = 20,
    parameter int DEPTH     = 4,
    parameter int LOG2DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset_b,
    ext_write_buffer_if.slave   bus,
    output logic                buf_empty,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    localparam logic [LOG2DEPTH:0]   FULL_CNT = (LOG2DEPTH+1)'(DEPTH);
    localparam logic [LOG2DEPTH:0]   CNT_ONE  = (LOG2DEPTH+1)'(1);
    localparam logic [LOG2DEPTH-1:0] PTR_ONE  = LOG2DEPTH'(1);

    state_e state_q, state_d;

    logic [ASIZE-1:0]     fifo_addr_q [DEPTH];
    logic [DSIZE-1:0]     fifo_data_q [DEPTH];
    logic [LOG2DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2DEPTH:0]   count_q, count_d;

    logic             mc_cs_b_q, mc_cs_b_d;
    logic             mc_rnw_q, mc_rnw_d;
    logic [ASIZE-1:0] mc_addr_q, mc_addr_d;
    logic [DSIZE-1:0] mc_dout_q, mc_dout_d;

    logic wr_req, rd_req, complete, fifo_empty, fifo_full;
    logic load_slot, pop, push, bypass;

    assign wr_req     = !bus.cpu_cs_b && !bus.cpu_rnw;
    assign rd_req     = !bus.cpu_cs_b &&  bus.cpu_rnw;
    assign complete   = !mc_cs_b_q && bus.mc_clken;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    // A new mc access may be loaded from idle, or back-to-back on a write completion.
    assign load_slot  = (state_q == IDLE) || ((state_q == WRITE) && complete);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty || wr_req) state_d = WRITE;
                else if (rd_req)           state_d = READ;
            end
            WRITE: begin
                if (complete) begin
                    if (!fifo_empty || wr_req) state_d = WRITE;
                    else if (rd_req)           state_d = READ;
                    else                       state_d = IDLE;
                end
            end
            READ: begin
                if (complete) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath control
    // The FIFO holds only writes not yet handed to the controller; the entry being
    // driven on mc_* lives in the mc registers. A write arriving with the FIFO empty
    // at a load slot bypasses the FIFO and goes straight onto the bus.
    always_comb begin
        mc_cs_b_d = mc_cs_b_q;
        mc_rnw_d  = mc_rnw_q;
        mc_addr_d = mc_addr_q;
        mc_dout_d = mc_dout_q;
        pop       = 1'b0;
        bypass    = 1'b0;

        if (load_slot) begin
            if (!fifo_empty) begin
                pop       = 1'b1;
                mc_cs_b_d = 1'b0;
                mc_rnw_d  = 1'b0;
                mc_addr_d = fifo_addr_q[rd_ptr_q];
                mc_dout_d = fifo_data_q[rd_ptr_q];
            end else if (wr_req) begin
                bypass    = 1'b1;
                mc_cs_b_d = 1'b0;
                mc_rnw_d  = 1'b0;
                mc_addr_d = bus.cpu_addr;
                mc_dout_d = bus.cpu_dout;
            end else if (rd_req) begin
                mc_cs_b_d = 1'b0;
                mc_rnw_d  = 1'b1;
                mc_addr_d = bus.cpu_addr;
            end else begin
                mc_cs_b_d = 1'b1;
                mc_rnw_d  = 1'b1;
            end
        end else if ((state_q == READ) && complete) begin
            mc_cs_b_d = 1'b1;
            mc_rnw_d  = 1'b1;
        end

        push = wr_req && !bypass && (!fifo_full || pop);

        if (bus.cpu_cs_b)     bus.cpu_clken = 1'b1;
        else if (!bus.cpu_rnw) bus.cpu_clken = !fifo_full || pop;
        else                  bus.cpu_clken = (state_q == READ) && complete;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            mc_cs_b_q <= 1'b1;
            mc_rnw_q  <= 1'b1;
            mc_addr_q <= '0;
            mc_dout_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mc_cs_b_q <= mc_cs_b_d;
            mc_rnw_q  <= mc_rnw_d;
            mc_addr_q <= mc_addr_d;
            mc_dout_q <= mc_dout_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.cpu_addr;
            fifo_data_q[wr_ptr_q] <= bus.cpu_dout;
        end
    end

    assign bus.cpu_din = bus.mc_din;
    assign bus.mc_cs_b = mc_cs_b_q;
    assign bus.mc_rnw  = mc_rnw_q;
    assign bus.mc_addr = mc_addr_q;
    assign bus.mc_dout = mc_dout_q;

    assign buf_empty = fifo_empty && (state_q == IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ext_write_buffer.sv
// Bench for ext_write_buffer: directed CPU traffic, an 8-cycle memory_controller
// model, and a scoreboard that checks every mc write and every CPU read result.
module tb_ext_write_buffer;

    localparam int DSIZE = 32;
    localparam int ASIZE = 20;

    logic       clock;
    logic       reset_b;
    logic       buf_empty;
    logic [1:0] dbg_state;

    ext_write_buffer_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

    ext_write_buffer #(.DSIZE(DSIZE), .ASIZE(ASIZE), .DEPTH(4), .LOG2DEPTH(2)) dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .bus       (bus.slave),
        .buf_empty (buf_empty),
        .dbg_state (dbg_state)
    );

    // ---------------------------------------------------------------- clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- controller model
    // 7 wait states then completion, restarting for back-to-back accesses.
    logic [2:0]       mc_cnt;
    logic [DSIZE-1:0] mem [256];

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b)          mc_cnt <= 3'd0;
        else if (!bus.mc_cs_b) mc_cnt <= mc_cnt + 3'd1;
        else                   mc_cnt <= 3'd0;
    end

    always @(posedge clock) begin
        if (reset_b && !bus.mc_cs_b && bus.mc_clken && !bus.mc_rnw)
            mem[bus.mc_addr[7:0]] <= bus.mc_dout;
    end

    assign bus.mc_clken = !bus.mc_cs_b && (mc_cnt == 3'd7);
    assign bus.mc_din   = mem[bus.mc_addr[7:0]];

    // ---------------------------------------------------------------- scoreboard
    int checks   = 0;
    int failures = 0;
    logic [ASIZE+DSIZE-1:0] exp_wr_q[$];
    logic [DSIZE-1:0]       exp_rd_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    logic             new_acc = 1'b1;
    logic             stable;
    logic [ASIZE-1:0] cur_addr;
    logic [DSIZE-1:0] cur_dout;
    logic             cur_rnw;

    always @(negedge clock) begin
        if (!reset_b) begin
            new_acc = 1'b1;
        end else begin
            if (!bus.mc_cs_b) begin
                if (new_acc) begin
                    cur_addr = bus.mc_addr;
                    cur_dout = bus.mc_dout;
                    cur_rnw  = bus.mc_rnw;
                    stable   = 1'b1;
                    if (bus.mc_rnw) check("rd_after_wr_drain", 64'(exp_wr_q.size()), 64'd0);
                end else if (bus.mc_addr !== cur_addr || bus.mc_dout !== cur_dout ||
                             bus.mc_rnw !== cur_rnw) begin
                    stable = 1'b0;
                end
                if (bus.mc_clken) begin
                    check("mc_stable", 64'(stable), 64'd1);
                    if (!bus.mc_rnw) begin
                        if (exp_wr_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_wr actual=%0h expected=none", bus.mc_addr);
                        end else begin
                            check("wr_order", 64'({bus.mc_addr, bus.mc_dout}), 64'(exp_wr_q.pop_front()));
                        end
                    end
                end
            end
            if (!bus.cpu_cs_b && bus.cpu_rnw && bus.cpu_clken) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rd actual=%0h expected=none", bus.cpu_din);
                end else begin
                    check("rd_data", 64'(bus.cpu_din), 64'(exp_rd_q.pop_front()));
                end
            end
            new_acc = bus.mc_cs_b || bus.mc_clken;
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic cpu_write(input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d, output int stall);
        bus.cpu_cs_b = 1'b0;
        bus.cpu_rnw  = 1'b0;
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        exp_wr_q.push_back({a, d});
        stall = 0;
        @(negedge clock);
        while (!bus.cpu_clken && stall < 200) begin
            stall++;
            @(negedge clock);
        end
        if (stall >= 200) check("wr_accept_timeout", 64'(stall), 64'd0);
        @(posedge clock);
        #1;
        bus.cpu_cs_b = 1'b1;
        bus.cpu_rnw  = 1'b1;
    endtask

    task automatic cpu_read(input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d, output int stall);
        bus.cpu_cs_b = 1'b0;
        bus.cpu_rnw  = 1'b1;
        bus.cpu_addr = a;
        exp_rd_q.push_back(d);
        stall = 0;
        @(negedge clock);
        while (!bus.cpu_clken && stall < 200) begin
            stall++;
            @(negedge clock);
        end
        if (stall >= 200) check("rd_accept_timeout", 64'(stall), 64'd0);
        @(posedge clock);
        #1;
        bus.cpu_cs_b = 1'b1;
    endtask

    // Counts cycles with mc_cs_b low, starting at the next falling edge.
    task automatic wait_low(output int n);
        n = 0;
        @(negedge clock);
        while (!bus.mc_cs_b && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    int st, n;
    int stalls [6];

    initial begin
        reset_b      = 1'b0;
        bus.cpu_cs_b = 1'b1;
        bus.cpu_rnw  = 1'b1;
        bus.cpu_addr = '0;
        bus.cpu_dout = '0;
        repeat (3) @(posedge clock);
        #1 reset_b = 1'b1;
        @(negedge clock);

        // 1: reset / idle values
        check("rst_mc_cs_b", 64'(bus.mc_cs_b), 64'd1);
        check("rst_mc_rnw", 64'(bus.mc_rnw), 64'd1);
        check("rst_mc_addr", 64'(bus.mc_addr), 64'd0);
        check("rst_mc_dout", 64'(bus.mc_dout), 64'd0);
        check("rst_buf_empty", 64'(buf_empty), 64'd1);
        check("rst_cpu_clken", 64'(bus.cpu_clken), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(posedge clock);
        #1;

        // 2: single write
        cpu_write(20'h00010, 32'h12345678, st);
        check("single_wr_stall", 64'(st), 64'd0);
        check("single_wr_issue_next_cycle", 64'(bus.mc_cs_b), 64'd0);
        wait_low(n);
        check("single_wr_len", 64'(n), 64'd8);
        check("single_wr_buf_empty", 64'(buf_empty), 64'd1);
        check("single_wr_rnw_idle", 64'(bus.mc_rnw), 64'd1);
        @(posedge clock);
        #1;

        // 3: DEPTH+2 back-to-back writes; only the last one stalls
        for (int i = 0; i < 6; i++)
            cpu_write(20'h00030 + 20'(i), 32'hA0000000 + 32'(i), stalls[i]);
        for (int i = 0; i < 5; i++)
            check($sformatf("b2b_wr%0d_stall", i), 64'(stalls[i]), 64'd0);
        check("b2b_wr5_stall", 64'(stalls[5]), 64'd3);
        wait_low(n);
        check("b2b_remaining_low", 64'(n), 64'd40);
        check("b2b_buf_empty", 64'(buf_empty), 64'd1);
        @(posedge clock);
        #1;

        // 4: write then read of the same address
        cpu_write(20'h00020, 32'hCAFEF00D, st);
        check("wr_rd_wr_stall", 64'(st), 64'd0);
        cpu_read(20'h00020, 32'hCAFEF00D, st);
        check("wr_rd_rd_stall", 64'(st), 64'd15);

        // 5: read from idle
        check("rd_idle_buf_empty", 64'(buf_empty), 64'd1);
        cpu_read(20'h00010, 32'h12345678, st);
        check("rd_idle_stall", 64'(st), 64'd8);
        @(posedge clock);
        #1;

        // 6: reset in the middle of a write with three entries queued
        for (int i = 0; i < 4; i++)
            cpu_write(20'h00040 + 20'(i), 32'hB0000000 + 32'(i), st);
        @(posedge clock);
        #3;
        check("pre_reset_busy", 64'(buf_empty), 64'd0);
        reset_b = 1'b0;
        #1;
        exp_wr_q.delete();
        check("async_rst_mc_cs_b", 64'(bus.mc_cs_b), 64'd1);
        check("async_rst_mc_rnw", 64'(bus.mc_rnw), 64'd1);
        check("async_rst_mc_addr", 64'(bus.mc_addr), 64'd0);
        check("async_rst_buf_empty", 64'(buf_empty), 64'd1);
        repeat (2) @(posedge clock);
        #1 reset_b = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clock);
            if (!bus.mc_cs_b) n++;
        end
        check("no_access_after_reset", 64'(n), 64'd0);
        check("post_reset_buf_empty", 64'(buf_empty), 64'd1);

        check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
        check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
